srm_controller: RTL

Moore-style control FSM for the Simple RISC Machine CPU. It sequences fetch, PC update, decode and execute. It consumes the opcode/op fields produced by the instruction decoder and drives the decoder's one-hot `nsel` register select. It also drives the datapath loads, the register-file write, the instruction-register and PC loads, and the memory command. It sits directly downstream of the instruction decoder and closes the loop back to it through `nsel`.

---
 rtl/srm_controller.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/srm_controller.sv
// srm_controller: Moore control FSM for the Simple RISC Machine.
// Sequences fetch (IF1/IF2), PC update, decode and a per-instruction
// execute path. All outputs are a pure function of the state register.
// The instruction class is captured once in DECODE, so later states never
// look at opcode/op again.
module srm_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       write,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       load_addr,
  output logic       addr_sel,
  output logic [1:0] mem_cmd,
  output logic       halted,
  output logic [4:0] state_dbg
);

  typedef enum logic [4:0] {
    S_RST       = 5'd0,
    S_IF1       = 5'd1,
    S_IF2       = 5'd2,
    S_UPDATE_PC = 5'd3,
    S_DECODE    = 5'd4,
    S_WR_IMM    = 5'd5,
    S_GET_A     = 5'd6,
    S_GET_B     = 5'd7,
    S_GET_RD    = 5'd8,
    S_EXEC      = 5'd9,
    S_EXEC_MOV  = 5'd10,
    S_EXEC_CMP  = 5'd11,
    S_PASS_B    = 5'd12,
    S_WR_RD     = 5'd13,
    S_ADDR      = 5'd14,
    S_LD_ADDR   = 5'd15,
    S_MEM_RD    = 5'd16,
    S_WR_MEM    = 5'd17,
    S_MEM_WR    = 5'd18,
    S_HALT      = 5'd19
  } state_t;

  // Instruction class, chosen in DECODE; steers the shared execute states.
  typedef enum logic [2:0] {
    K_MOV  = 3'd0,  // MOV reg and MVN: B only, then writeback
    K_ALU  = 3'd1,  // ADD / AND: A and B, then writeback
    K_CMP  = 3'd2,  // CMP: A and B, status only
    K_LDR  = 3'd3,
    K_STR  = 3'd4,
    K_IMM  = 3'd5,  // MOV immediate
    K_HALT = 3'd6   // HALT and every undefined encoding
  } kind_t;

  localparam logic [2:0] NSEL_RM  = 3'b001;
  localparam logic [2:0] NSEL_RD  = 3'b010;
  localparam logic [2:0] NSEL_RN  = 3'b100;
  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b10;
  localparam logic [1:0] VSEL_MEM = 2'b11;
  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_RD   = 2'b01;
  localparam logic [1:0] MEM_WR   = 2'b10;

  state_t state, state_next;
  kind_t  kind_q, kind_dec;

  assign state_dbg = state;

  // Classify the decoder fields; only meaningful while in DECODE.
  always_comb begin
    kind_dec = K_HALT;
    case ({opcode, op})
      5'b110_10: kind_dec = K_IMM;
      5'b110_00: kind_dec = K_MOV;
      5'b101_11: kind_dec = K_MOV;
      5'b101_00: kind_dec = K_ALU;
      5'b101_10: kind_dec = K_ALU;
      5'b101_01: kind_dec = K_CMP;
      5'b011_00: kind_dec = K_LDR;
      5'b100_00: kind_dec = K_STR;
      default:   kind_dec = K_HALT;
    endcase
  end

  // State register; reset lands in RST without waiting for a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_RST;
    else          state <= state_next;
  end

  // Instruction class register, loaded only on the DECODE edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               kind_q <= K_HALT;
    else if (state == S_DECODE) kind_q <= kind_dec;
  end

  // Next-state logic: one cycle per state, no stalls.
  always_comb begin
    state_next = state;
    case (state)
      S_RST:       state_next = S_IF1;
      S_IF1:       state_next = S_IF2;
      S_IF2:       state_next = S_UPDATE_PC;
      S_UPDATE_PC: state_next = S_DECODE;
      S_DECODE: begin
        case (kind_dec)
          K_IMM:                  state_next = S_WR_IMM;
          K_MOV:                  state_next = S_GET_B;
          K_ALU, K_CMP:           state_next = S_GET_A;
          K_LDR, K_STR:           state_next = S_GET_A;
          default:                state_next = S_HALT;
        endcase
      end
      S_WR_IMM:    state_next = S_IF1;
      S_GET_A: begin
        if (kind_q == K_LDR || kind_q == K_STR) state_next = S_ADDR;
        else                                    state_next = S_GET_B;
      end
      S_GET_B: begin
        case (kind_q)
          K_MOV:   state_next = S_EXEC_MOV;
          K_CMP:   state_next = S_EXEC_CMP;
          default: state_next = S_EXEC;
        endcase
      end
      S_EXEC:      state_next = S_WR_RD;
      S_EXEC_MOV:  state_next = S_WR_RD;
      S_EXEC_CMP:  state_next = S_IF1;
      S_WR_RD:     state_next = S_IF1;
      S_ADDR:      state_next = S_LD_ADDR;
      S_LD_ADDR: begin
        if (kind_q == K_STR) state_next = S_GET_RD;
        else                 state_next = S_MEM_RD;
      end
      S_MEM_RD:    state_next = S_WR_MEM;
      S_WR_MEM:    state_next = S_IF1;
      S_GET_RD:    state_next = S_PASS_B;
      S_PASS_B:    state_next = S_MEM_WR;
      S_MEM_WR:    state_next = S_IF1;
      S_HALT:      state_next = S_HALT;
      default:     state_next = S_RST;
    endcase
  end

  // Moore output decode: everything defaults to 0, each state raises its own.
  always_comb begin
    nsel      = 3'b000;
    vsel      = VSEL_C;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    write     = 1'b0;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    load_addr = 1'b0;
    addr_sel  = 1'b0;
    mem_cmd   = MEM_NONE;
    halted    = 1'b0;
    case (state)
      S_RST: begin
        reset_pc = 1'b1;
        load_pc  = 1'b1;
      end
      S_IF1: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_RD;
      end
      S_IF2: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_RD;
        load_ir  = 1'b1;
      end
      S_UPDATE_PC: load_pc = 1'b1;
      S_WR_IMM: begin
        nsel  = NSEL_RN;
        vsel  = VSEL_IMM;
        write = 1'b1;
      end
      S_GET_A: begin
        nsel  = NSEL_RN;
        loada = 1'b1;
      end
      S_GET_B: begin
        nsel  = NSEL_RM;
        loadb = 1'b1;
      end
      S_GET_RD: begin
        nsel  = NSEL_RD;
        loadb = 1'b1;
      end
      S_EXEC:     loadc = 1'b1;
      S_EXEC_MOV: begin
        asel  = 1'b1;
        loadc = 1'b1;
      end
      S_EXEC_CMP: loads = 1'b1;
      S_PASS_B: begin
        asel  = 1'b1;
        loadc = 1'b1;
      end
      S_WR_RD: begin
        nsel  = NSEL_RD;
        vsel  = VSEL_C;
        write = 1'b1;
      end
      S_ADDR: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      S_LD_ADDR: load_addr = 1'b1;
      S_MEM_RD:  mem_cmd = MEM_RD;
      S_WR_MEM: begin
        mem_cmd = MEM_RD;
        nsel    = NSEL_RD;
        vsel    = VSEL_MEM;
        write   = 1'b1;
      end
      S_MEM_WR: mem_cmd = MEM_WR;
      S_HALT:   halted = 1'b1;
      default: ;
    endcase
  end

endmodule
